// File: rtl/tile_stream_writer_if.sv
// Bus bundle for tile_stream_writer: tile control, the input element
// stream and the registered tile-buffer write port.
interface tile_stream_writer_if #(
   parameter int DW = 32,
   parameter int AW = 16
);
   logic          start;
   logic [AW-1:0] base_addr;
   logic          abort;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          wr_ena;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          busy;
   logic          done;

   // Producer / controller side.
   modport master (
      output start, base_addr, abort, in_valid, in_data,
      input  in_ready, wr_ena, wr_addr, wr_data, busy, done
   );

   // Writer side.
   modport slave (
      input  start, base_addr, abort, in_valid, in_data,
      output in_ready, wr_ena, wr_addr, wr_data, busy, done
   );
endinterface

// File: rtl/tile_stream_writer.sv
// Tile stream writer: consumes an element stream in row-major order
// (inner index fastest) and writes each element to
// base + row*ROW_STRIDE + col. The row term is accumulated by adding the
// stride at every row end, so no multiplier is needed. Pulses done with
// the last write of an n1_max x n0_max tile.
module tile_stream_writer #(
   parameter int CW         = 16,
   parameter int DW         = 32,
   parameter int AW         = 16,
   parameter int n0_max     = 64,
   parameter int n1_max     = 16,
   parameter int ROW_STRIDE = 64
) (
   input  logic                clk,
   input  logic                rst,
   tile_stream_writer_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [CW-1:0] N0_LAST = CW'(n0_max - 1);
   localparam logic [CW-1:0] N1_LAST = CW'(n1_max - 1);
   localparam logic [AW-1:0] STRIDE  = AW'(ROW_STRIDE);

   state_t          state, state_nx;
   logic [CW-1:0]   cnt0, cnt1;
   logic [AW-1:0]   row_base;
   logic            hs_p0, row_end_p0, tile_end_p0;
   logic            wr_ena_p1, done_p1;
   logic [AW-1:0]   wr_addr_p1;
   logic [DW-1:0]   wr_data_p1;

   // Element address within the buffer; wraps modulo 2^AW.
   function automatic logic [AW-1:0] elem_addr(input logic [AW-1:0] rb,
                                                input logic [CW-1:0] c0);
      return rb + AW'(c0);
   endfunction

   // An element handshaken during an abort cycle is dropped entirely.
   assign hs_p0       = bus.in_valid && (state == RUN) && !bus.abort;
   assign row_end_p0  = (cnt0 == N0_LAST);
   assign tile_end_p0 = row_end_p0 && (cnt1 == N1_LAST);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next state and state-decoded outputs; in_ready depends on state only.
   always_comb begin
      state_nx     = state;
      bus.in_ready = 1'b0;
      bus.busy     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_nx = RUN;
         end
         RUN: begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b1;
            if (hs_p0 && tile_end_p0) state_nx = DONE;
         end
         DONE: begin
            bus.busy = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (bus.abort) state_nx = IDLE;
   end

   // Nested element counters and running row base address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt0     <= '0;
         cnt1     <= '0;
         row_base <= '0;
      end else if (bus.abort) begin
         cnt0     <= '0;
         cnt1     <= '0;
         row_base <= '0;
      end else if (state == IDLE && bus.start) begin
         cnt0     <= '0;
         cnt1     <= '0;
         row_base <= bus.base_addr;
      end else if (hs_p0) begin
         if (row_end_p0) begin
            cnt0     <= '0;
            cnt1     <= cnt1 + 1'b1;
            row_base <= row_base + STRIDE;
         end else begin
            cnt0 <= cnt0 + 1'b1;
         end
      end
   end

   // ---- stage p0 -> p1: registered buffer write port and done pulse ----
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ena_p1  <= 1'b0;
         done_p1    <= 1'b0;
         wr_addr_p1 <= '0;
         wr_data_p1 <= '0;
      end else begin
         wr_ena_p1 <= hs_p0;
         done_p1   <= hs_p0 && tile_end_p0;
         if (hs_p0) begin
            wr_addr_p1 <= elem_addr(row_base, cnt0);
            wr_data_p1 <= bus.in_data;
         end
      end
   end

   assign bus.wr_ena  = wr_ena_p1;
   assign bus.wr_addr = wr_addr_p1;
   assign bus.wr_data = wr_data_p1;
   assign bus.done    = done_p1;

endmodule

// File: tb/tb_tile_stream_writer.sv
// Testbench for tile_stream_writer: two instances (16-bit and 8-bit
// address space) driven by directed steps with random data/valid, checked
// every cycle against an element-count based reference model.
module tb_tile_stream_writer;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   tile_stream_writer_if #(.DW(32), .AW(16)) ia ();
   tile_stream_writer_if #(.DW(32), .AW(8))  ib ();

   tile_stream_writer #(.CW(16), .DW(32), .AW(16), .n0_max(4), .n1_max(3),
                        .ROW_STRIDE(8)) dut_a (.clk(clk), .rst(rst), .bus(ia));
   tile_stream_writer #(.CW(16), .DW(32), .AW(8), .n0_max(4), .n1_max(2),
                        .ROW_STRIDE(4)) dut_b (.clk(clk), .rst(rst), .bus(ib));

   // Model parameters per instance.
   int     n0m [2] = '{4, 4};
   int     n1m [2] = '{3, 2};
   int     stm [2] = '{8, 4};
   longint mask[2] = '{64'hFFFF, 64'hFF};

   // Model status: mode 0 idle, 1 accepting, 2 finished; k = elements taken.
   int          mode  [2];
   int          k     [2];
   longint      mb    [2];
   bit          e_ena [2];
   bit          e_done[2];
   longint      e_addr[2];
   logic [31:0] e_data[2];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         mode[d] = 0; k[d] = 0; mb[d] = 0;
         e_ena[d] = 1'b0; e_done[d] = 1'b0; e_addr[d] = 0; e_data[d] = '0;
      end
   endtask

   // Predict the outputs after the coming clock edge from current inputs.
   task automatic model_pre();
      for (int d = 0; d < 2; d++) begin
         bit st, ab, vl, hs;
         longint bs;
         logic [31:0] dt;
         if (d == 0) begin
            st = ia.start; ab = ia.abort; vl = ia.in_valid; bs = ia.base_addr; dt = ia.in_data;
         end else begin
            st = ib.start; ab = ib.abort; vl = ib.in_valid; bs = ib.base_addr; dt = ib.in_data;
         end
         hs = (mode[d] == 1) && vl && !ab;
         e_ena[d]  = hs;
         e_done[d] = hs && (k[d] == n0m[d] * n1m[d] - 1);
         if (hs) begin
            e_addr[d] = (mb[d] + (k[d] / n0m[d]) * stm[d] + (k[d] % n0m[d])) & mask[d];
            e_data[d] = dt;
         end
         if (ab) begin
            mode[d] = 0; k[d] = 0;
         end else begin
            case (mode[d])
               0: if (st) begin mode[d] = 1; k[d] = 0; mb[d] = bs; end
               1: if (hs) begin
                     k[d]++;
                     if (k[d] == n0m[d] * n1m[d]) mode[d] = 2;
                  end
               default: mode[d] = 0;
            endcase
         end
      end
   endtask

   task automatic checks();
      chk("A_in_ready", ia.in_ready, (mode[0] == 1));
      chk("A_busy",     ia.busy,     (mode[0] != 0));
      chk("A_wr_ena",   ia.wr_ena,   e_ena[0]);
      chk("A_done",     ia.done,     e_done[0]);
      chk("A_wr_addr",  ia.wr_addr,  e_addr[0]);
      chk("A_wr_data",  ia.wr_data,  e_data[0]);
      chk("B_in_ready", ib.in_ready, (mode[1] == 1));
      chk("B_busy",     ib.busy,     (mode[1] != 0));
      chk("B_wr_ena",   ib.wr_ena,   e_ena[1]);
      chk("B_done",     ib.done,     e_done[1]);
      chk("B_wr_addr",  ib.wr_addr,  e_addr[1]);
      chk("B_wr_data",  ib.wr_data,  e_data[1]);
   endtask

   // One clock: predict, clock, then compare mid-cycle.
   task automatic step();
      model_pre();
      @(posedge clk);
      #1;
      checks();
   endtask

   task automatic start_a(input logic [15:0] b);
      ia.start = 1'b1; ia.base_addr = b;
      step();
      ia.start = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      ia.start = 0; ia.base_addr = '0; ia.abort = 0; ia.in_valid = 0; ia.in_data = '0;
      ib.start = 0; ib.base_addr = '0; ib.abort = 0; ib.in_valid = 0; ib.in_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks();
      rst = 1'b0;
      step();

      // Basic tile, in_valid held high, random data.
      start_a(16'h0100);
      ia.in_valid = 1'b1;
      repeat (14) begin ia.in_data = $urandom; step(); end
      ia.in_valid = 1'b0;
      repeat (2) step();

      // Bubbles: in_valid toggling 1,0,1,0...
      start_a(16'h0100);
      for (int i = 0; i < 26; i++) begin
         ia.in_valid = (i % 2 == 0);
         ia.in_data  = $urandom;
         step();
      end
      ia.in_valid = 1'b0;
      step();

      // Address wrap on the 8-bit instance.
      ib.start = 1'b1; ib.base_addr = 8'hFC;
      step();
      ib.start = 1'b0; ib.in_valid = 1'b1;
      repeat (10) begin ib.in_data = $urandom; step(); end
      ib.in_valid = 1'b0;
      step();

      // Start during RUN and DONE is ignored; start right after DONE accepted.
      start_a(16'h0100);
      ia.in_valid = 1'b1;
      repeat (5) begin ia.in_data = $urandom; step(); end
      ia.start = 1'b1; ia.base_addr = 16'h0200; ia.in_data = $urandom;
      step();
      ia.start = 1'b0;
      repeat (6) begin ia.in_data = $urandom; step(); end
      ia.in_valid = 1'b0;
      ia.start = 1'b1; ia.base_addr = 16'h0300;     // arrives during DONE
      step();
      ia.base_addr = 16'h0200;                      // arrives in IDLE
      step();
      ia.start = 1'b0;
      for (int i = 0; i < 200 && mode[0] != 0; i++) begin
         ia.in_valid = $urandom_range(0, 1);
         ia.in_data  = $urandom;
         step();
      end
      ia.in_valid = 1'b0;
      chk("A_random_tile_finished", ia.busy, 1'b0);
      step();

      // Abort after 6 elements, then restart at base 0.
      start_a(16'h0100);
      ia.in_valid = 1'b1;
      repeat (6) begin ia.in_data = $urandom; step(); end
      ia.abort = 1'b1; ia.in_data = $urandom;
      step();
      ia.abort = 1'b0; ia.in_valid = 1'b0;
      step();
      start_a(16'h0000);
      ia.in_valid = 1'b1;
      repeat (3) begin ia.in_data = $urandom; step(); end
      ia.in_valid = 1'b0; ia.abort = 1'b1;
      step();
      ia.abort = 1'b0;
      step();

      // Asynchronous reset mid-tile.
      start_a(16'h0100);
      ia.in_valid = 1'b1;
      repeat (7) begin ia.in_data = $urandom; step(); end
      #2 rst = 1'b1;
      #1;
      model_reset();
      checks();
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) begin ia.in_data = $urandom; step(); end
      ia.in_valid = 1'b0;
      start_a(16'h0040);
      ia.in_valid = 1'b1;
      repeat (2) begin ia.in_data = $urandom; step(); end
      ia.in_valid = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
